// File: rtl/alu_sequencer.sv
// Sequential front-end for a combinational n-bit ALU: one request at a time,
// result captured into an accumulator/carry flag and returned over valid/ready.
module alu_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_data,
  input  logic         in_usec,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_mode,
  output logic         alu_cin,
  input  logic [N-1:0] alu_y,
  input  logic         alu_cout,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_carry,
  output logic         out_zero,
  output logic         out_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side data must be held stable until that edge.
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_CLRC = 4'd9;

  state_t       state_q, state_d;
  logic [N-1:0] acc_q, acc_d;
  logic [N-1:0] b_q, b_d;
  logic [3:0]   op_q, op_d;
  logic         usec_q, usec_d;
  logic         cflag_q, cflag_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      op_q    <= '0;
      usec_q  <= 1'b0;
      cflag_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      op_q    <= op_d;
      usec_q  <= usec_d;
      cflag_q <= cflag_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    op_d    = op_q;
    usec_d  = usec_q;
    cflag_d = cflag_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          b_d     = in_data;
          usec_d  = in_usec;
          state_d = EXEC;
        end
      end
      EXEC: begin
        err_d = 1'b0;
        if (!op_q[3]) begin
          acc_d = alu_y;
          // Modes 000/001/110/111 are arithmetic and update the carry.
          if (op_q[2] == op_q[1]) cflag_d = alu_cout;
        end else if (op_q == OP_LOAD) begin
          acc_d = b_q;
        end else if (op_q == OP_CLRC) begin
          cflag_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == RESP);
  assign out_data  = acc_q;
  assign out_carry = cflag_q;
  assign out_zero  = (acc_q == '0);
  assign out_err   = err_q;

  assign alu_a    = acc_q;
  assign alu_b    = b_q;
  assign alu_mode = op_q[2:0];
  assign alu_cin  = usec_q & cflag_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural model of the attached ALU.
module tb_alu_sequencer;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [N-1:0] in_data;
  logic         in_usec;
  logic [N-1:0] alu_a, alu_b, alu_y;
  logic [2:0]   alu_mode;
  logic         alu_cin, alu_cout;
  logic         out_valid, out_ready;
  logic [N-1:0] out_data;
  logic         out_carry, out_zero, out_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_data(in_data), .in_usec(in_usec),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .out_zero(out_zero), .out_err(out_err)
  );

  // ALU model: 0 add, 1 sub (cout=borrow), 2 and, 3 or, 4 xor, 5 not a, 6 inc, 7 dec.
  logic [N:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (alu_mode)
      3'd0: alu_t = {1'b0, alu_a} + {1'b0, alu_b} + (N+1)'(alu_cin);
      3'd1: alu_t = {1'b0, alu_a} - {1'b0, alu_b} - (N+1)'(alu_cin);
      3'd2: alu_t = {1'b0, alu_a & alu_b};
      3'd3: alu_t = {1'b0, alu_a | alu_b};
      3'd4: alu_t = {1'b0, alu_a ^ alu_b};
      3'd5: alu_t = {1'b0, ~alu_a};
      3'd6: alu_t = {1'b0, alu_a} + (N+1)'(1) + (N+1)'(alu_cin);
      default: alu_t = {1'b0, alu_a} - (N+1)'(1) - (N+1)'(alu_cin);
    endcase
  end
  assign alu_y    = alu_t[N-1:0];
  assign alu_cout = alu_t[N];

  // Response packed as {data, carry, zero, err}.
  logic [N+2:0] r;
  int           lat;

  task automatic send_req(input logic [3:0] op, input logic [N-1:0] d, input logic usec,
                          output logic [N+2:0] resp, output int latency);
    int  w;
    bit  seen;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d; in_usec = usec;
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    latency = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin seen = 1'b1; break; end
      @(posedge clk);
      latency++;
    end
    if (!seen) latency = -1;
    resp = {out_data, out_carry, out_zero, out_err};
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_data = '0; in_usec = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({in_ready, out_valid, out_data, out_carry, out_zero, out_err} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL reset_out got=%b exp=%b", {in_ready, out_valid, out_data, out_carry, out_zero, out_err}, 9'b1_0_0000_0_1_0); end
    checks++; if ({alu_a, alu_b, alu_mode, alu_cin} !== 12'h000) begin
      failures++; $display("FAIL reset_alu got=%h exp=000", {alu_a, alu_b, alu_mode, alu_cin}); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    send_req(4'd8, 4'h9, 1'b0, r, lat);
    checks++; if (r !== {4'h9, 3'b000}) begin failures++; $display("FAIL load9 got=%b exp=%b", r, {4'h9, 3'b000}); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL load9_latency got=%0d exp=2", lat); end
    next_edge();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL ready_after_resp got=%b exp=10", {in_ready, out_valid}); end
    send_req(4'd0, 4'h8, 1'b0, r, lat);
    checks++; if (r !== {4'h1, 3'b100}) begin failures++; $display("FAIL add_9_8 got=%b exp=%b", r, {4'h1, 3'b100}); end
    checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat); end
    next_edge();
  endtask

  task automatic test_multiword();
    send_req(4'd8, 4'hF, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'hF, 3'b100}) begin failures++; $display("FAIL lo_load got=%b exp=%b", r, {4'hF, 3'b100}); end
    send_req(4'd0, 4'h1, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h0, 3'b110}) begin failures++; $display("FAIL lo_add got=%b exp=%b", r, {4'h0, 3'b110}); end
    send_req(4'd8, 4'hF, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'hF, 3'b100}) begin failures++; $display("FAIL hi_load_keeps_carry got=%b exp=%b", r, {4'hF, 3'b100}); end
    send_req(4'd0, 4'h0, 1'b1, r, lat); next_edge();
    checks++; if (r !== {4'h0, 3'b110}) begin failures++; $display("FAIL hi_add_cin got=%b exp=%b", r, {4'h0, 3'b110}); end
  endtask

  task automatic test_decrement();
    send_req(4'd8, 4'h0, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h0, 3'b110}) begin failures++; $display("FAIL load0 got=%b exp=%b", r, {4'h0, 3'b110}); end
    send_req(4'd7, 4'h0, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'hF, 3'b100}) begin failures++; $display("FAIL dec_wrap got=%b exp=%b", r, {4'hF, 3'b100}); end
    send_req(4'd9, 4'h0, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'hF, 3'b000}) begin failures++; $display("FAIL clrc got=%b exp=%b", r, {4'hF, 3'b000}); end
  endtask

  task automatic test_logic();
    send_req(4'd6, 4'h0, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h0, 3'b110}) begin failures++; $display("FAIL inc_wrap got=%b exp=%b", r, {4'h0, 3'b110}); end
    send_req(4'd8, 4'hC, 1'b0, r, lat); next_edge();
    send_req(4'd2, 4'h3, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h0, 3'b110}) begin failures++; $display("FAIL and_keeps_carry got=%b exp=%b", r, {4'h0, 3'b110}); end
    send_req(4'd4, 4'h5, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h5, 3'b100}) begin failures++; $display("FAIL xor got=%b exp=%b", r, {4'h5, 3'b100}); end
  endtask

  task automatic test_illegal();
    send_req(4'd8, 4'h5, 1'b0, r, lat); next_edge();
    send_req(4'hB, 4'h2, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h5, 3'b101}) begin failures++; $display("FAIL illegal got=%b exp=%b", r, {4'h5, 3'b101}); end
    send_req(4'd3, 4'h2, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h7, 3'b100}) begin failures++; $display("FAIL err_clears got=%b exp=%b", r, {4'h7, 3'b100}); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send_req(4'd8, 4'h6, 1'b0, r, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_op = 4'd8; in_data = 4'hA;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({out_valid, in_ready, out_data, out_carry, out_zero, out_err} !== {1'b1, 1'b0, 4'h6, 3'b100}) begin
        failures++; $display("FAIL hold_%0d got=%b exp=%b", i, {out_valid, in_ready, out_data, out_carry, out_zero, out_err}, {1'b1, 1'b0, 4'h6, 3'b100}); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    next_edge();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL release got=%b exp=10", {in_ready, out_valid}); end
    send_req(4'd3, 4'h0, 1'b0, r, lat); next_edge();
    checks++; if (r !== {4'h6, 3'b100}) begin failures++; $display("FAIL pulses_ignored got=%b exp=%b", r, {4'h6, 3'b100}); end
  endtask

  task automatic test_reset_mid_exec();
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd8; in_data = 4'h3; in_usec = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({in_ready, out_valid, out_data, out_carry, out_zero, out_err} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL mid_reset_out got=%b exp=%b", {in_ready, out_valid, out_data, out_carry, out_zero, out_err}, 9'b1_0_0000_0_1_0); end
    checks++; if ({alu_a, alu_b, alu_mode, alu_cin} !== 12'h000) begin
      failures++; $display("FAIL mid_reset_alu got=%h exp=000", {alu_a, alu_b, alu_mode, alu_cin}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL no_resp_after_reset got=%b exp=0", out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multiword();
    test_decrement();
    test_logic();
    test_illegal();
    test_backpressure();
    test_reset_mid_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
